// File: rtl/fir_sample_feeder.sv
// Sample feeder for the FIR datapath: host-loaded FIFO drained at a programmable period.
// Optional macro FIR_FEEDER_LOOP_EN adds a loop port that replays the buffer cyclically.
module fir_sample_feeder #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int DIV_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic                       start,
  input  logic                       stop,
  input  logic [DIV_W-1:0]           div,
`ifdef FIR_FEEDER_LOOP_EN
  input  logic                       loop,
`endif
  output logic [DATA_W-1:0]          sample_out,
  output logic                       sample_stb,
  output logic                       running,
  output logic                       underflow,
  output logic [$clog2(DEPTH):0]     level
);

  // state | meaning
  // IDLE  | not streaming; FIFO may be loaded, contents kept
  // RUN   | divider counting down; one sample emitted per terminal count
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  state_t              state_q;
  logic [DIV_W-1:0]    cnt_q;
  logic [AW-1:0]       rd_ptr_q, wr_ptr_q;
  logic [LW-1:0]       level_q, level_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   sample_q;
  logic                stb_q, underflow_q;

  logic                loop_on, full, empty, due, pop, push;
  logic [DATA_W-1:0]   push_data;

`ifdef FIR_FEEDER_LOOP_EN
  assign loop_on = (state_q == RUN) && loop;
`else
  assign loop_on = 1'b0;
`endif

  assign full      = (level_q == LW'(DEPTH));
  assign empty     = (level_q == '0);
  assign wr_ready  = ena && !full && !loop_on;
  assign due       = ena && (state_q == RUN) && !stop && (cnt_q == '0);
  assign pop       = due && !empty;
  // In loop mode the popped head is re-queued at the tail in the same cycle.
  assign push      = (ena && wr_valid && wr_ready) || (pop && loop_on);
  assign push_data = loop_on ? mem_q[rd_ptr_q] : wr_data;

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      level_q     <= '0;
      sample_q    <= '0;
      stb_q       <= 1'b0;
      underflow_q <= 1'b0;
    end else if (ena) begin
      stb_q   <= 1'b0;
      level_q <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            state_q     <= RUN;
            cnt_q       <= div;
            underflow_q <= 1'b0;
          end
        end
        RUN: begin
          if (stop) begin
            state_q <= IDLE;
          end else if (cnt_q == '0) begin
            cnt_q <= div;
            stb_q <= 1'b1;
            if (!empty) begin
              sample_q <= mem_q[rd_ptr_q];
            end else begin
              sample_q    <= '0;
              underflow_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - DIV_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end else begin
      stb_q <= 1'b0;
    end
  end

  assign sample_out = sample_q;
  assign sample_stb = stb_q;
  assign running    = (state_q == RUN);
  assign underflow  = underflow_q;
  assign level      = level_q;

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Directed self-checking bench for fir_sample_feeder; loop replay exercised when
// FIR_FEEDER_LOOP_EN is defined.
module tb_fir_sample_feeder;

  logic       clk, rst_n, ena;
  logic [7:0] wr_data;
  logic       wr_valid, wr_ready, start, stop;
  logic [7:0] div;
  logic [7:0] sample_out;
  logic       sample_stb, running, underflow;
  logic [3:0] level;
`ifdef FIR_FEEDER_LOOP_EN
  logic       loop;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  fir_sample_feeder #(.DATA_W(8), .DEPTH(8), .DIV_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .start(start), .stop(stop), .div(div),
`ifdef FIR_FEEDER_LOOP_EN
    .loop(loop),
`endif
    .sample_out(sample_out), .sample_stb(sample_stb), .running(running),
    .underflow(underflow), .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // {sample_out, sample_stb, running, underflow, level, wr_ready}
  function automatic logic [15:0] status();
    return {sample_out, sample_stb, running, underflow, level, wr_ready};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_chk++;
    if (status() !== {8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1}) begin
      n_fail++; $display("FAIL reset_in got %h exp %h", status(), {8'h00, 7'b0000001});
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
    n_chk++;
    if (status() !== {8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1}) begin
      n_fail++; $display("FAIL reset_out got %h exp %h", status(), {8'h00, 7'b0000001});
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      wr_data = 8'(i); wr_valid = 1'b1;
      tick();
      n_chk++;
      if (level !== 4'(i)) begin
        n_fail++; $display("FAIL fill_level%0d got %0d exp %0d", i, level, i);
      end
    end
    n_chk++;
    if (wr_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_wr_ready got %b exp 0", wr_ready);
    end
    wr_data = 8'hFF;
    tick();
    wr_valid = 1'b0;
    n_chk++;
    if (level !== 4'd8) begin
      n_fail++; $display("FAIL overflow_level got %0d exp 8", level);
    end
  endtask

  task automatic test_stream();
    div = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    n_chk++;
    if (running !== 1'b1) begin
      n_fail++; $display("FAIL start_running got %b exp 1", running);
    end
    // strobes at +4,+8,..,+20; then cnt hits 0 again at +24 where stop arrives
    for (int i = 1; i <= 23; i++) begin
      logic exp_stb;
      exp_stb = (i % 4 == 0);
      tick();
      n_chk++;
      if (sample_stb !== exp_stb) begin
        n_fail++; $display("FAIL stream_stb t%0d got %b exp %b", i, sample_stb, exp_stb);
      end
      if (exp_stb) begin
        n_chk++;
        if ({sample_out, level} !== {8'(i / 4), 4'(8 - i / 4)}) begin
          n_fail++; $display("FAIL stream_data t%0d got %h/%0d exp %h/%0d",
                             i, sample_out, level, i / 4, 8 - i / 4);
        end
      end
    end
  endtask

  task automatic test_stop_restart();
    int strobes;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_chk++;
    if ({running, sample_stb, level} !== {1'b0, 1'b0, 4'd3}) begin
      n_fail++; $display("FAIL stop_due got run=%b stb=%b lvl=%0d exp 0 0 3",
                         running, sample_stb, level);
    end
    strobes = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (sample_stb) strobes++;
    end
    n_chk++;
    if ({strobes, level} !== {32'd0, 4'd3}) begin
      n_fail++; $display("FAIL idle_hold got stb=%0d lvl=%0d exp 0 3", strobes, level);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i % 4 == 0) begin
        n_chk++;
        if ({sample_stb, sample_out, level} !== {1'b1, 8'(5 + i / 4), 4'(3 - i / 4)}) begin
          n_fail++; $display("FAIL restart t%0d got %b/%h/%0d exp 1/%h/%0d",
                             i, sample_stb, sample_out, level, 5 + i / 4, 3 - i / 4);
        end
      end
    end
  endtask

  task automatic test_underflow();
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 3) begin
        n_chk++;
        if ({sample_stb, sample_out} !== {1'b0, 8'h08}) begin
          n_fail++; $display("FAIL hold_sample got %b/%h exp 0/08", sample_stb, sample_out);
        end
      end
    end
    n_chk++;
    if ({sample_stb, sample_out, underflow} !== {1'b1, 8'h00, 1'b1}) begin
      n_fail++; $display("FAIL underflow got %b/%h/%b exp 1/00/1", sample_stb, sample_out, underflow);
    end
    tick(); tick(); tick();
    // write landing on a due cycle with empty FIFO: no fall-through
    wr_data = 8'h55; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    n_chk++;
    if ({sample_stb, sample_out, level, underflow} !== {1'b1, 8'h00, 4'd1, 1'b1}) begin
      n_fail++; $display("FAIL no_fallthrough got %b/%h/%0d/%b exp 1/00/1/1",
                         sample_stb, sample_out, level, underflow);
    end
    tick(); tick(); tick(); tick();
    n_chk++;
    if ({sample_stb, sample_out, level, underflow} !== {1'b1, 8'h55, 4'd0, 1'b1}) begin
      n_fail++; $display("FAIL late_pop got %b/%h/%0d/%b exp 1/55/0/1",
                         sample_stb, sample_out, level, underflow);
    end
    // start while running must not reload the divider or clear underflow
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    n_chk++;
    if ({sample_stb, underflow} !== {1'b1, 1'b1}) begin
      n_fail++; $display("FAIL start_in_run got stb=%b uf=%b exp 1 1", sample_stb, underflow);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    n_chk++;
    if ({running, underflow} !== {1'b1, 1'b0}) begin
      n_fail++; $display("FAIL start_clears_uf got run=%b uf=%b exp 1 0", running, underflow);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_ena();
    ena = 1'b0; wr_valid = 1'b1; wr_data = 8'h99; start = 1'b1;
    #1;
    n_chk++;
    if (wr_ready !== 1'b0) begin
      n_fail++; $display("FAIL ena_wr_ready got %b exp 0", wr_ready);
    end
    tick();
    n_chk++;
    if ({running, level} !== {1'b0, 4'd0}) begin
      n_fail++; $display("FAIL ena_freeze got run=%b lvl=%0d exp 0 0", running, level);
    end
    ena = 1'b1; wr_valid = 1'b0; start = 1'b0;
    #1;
    n_chk++;
    if (wr_ready !== 1'b1) begin
      n_fail++; $display("FAIL ena_ready_back got %b exp 1", wr_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_s [4];
    logic [3:0] exp_l [4];
    exp_s = '{8'h11, 8'h22, 8'h44, 8'h00};
    exp_l = '{4'd2, 4'd1, 4'd0, 4'd0};
    wr_valid = 1'b1; wr_data = 8'h11; tick();
    wr_data = 8'h22; tick();
    wr_valid = 1'b0;
    div = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin wr_valid = 1'b1; wr_data = 8'h44; end
      tick();
      wr_valid = 1'b0;
      n_chk++;
      if ({sample_stb, sample_out, level} !== {1'b1, exp_s[i], exp_l[i]}) begin
        n_fail++; $display("FAIL div0 t%0d got %b/%h/%0d exp 1/%h/%0d",
                           i, sample_stb, sample_out, level, exp_s[i], exp_l[i]);
      end
    end
    n_chk++;
    if (underflow !== 1'b1) begin
      n_fail++; $display("FAIL div0_underflow got %b exp 1", underflow);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_reset_mid();
    wr_valid = 1'b1; wr_data = 8'h77; tick();
    wr_data = 8'h78; tick();
    wr_valid = 1'b0;
    div = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    n_chk++;
    if ({sample_stb, sample_out, running, level} !== {1'b1, 8'h77, 1'b1, 4'd1}) begin
      n_fail++; $display("FAIL pre_reset got %b/%h/%b/%0d exp 1/77/1/1",
                         sample_stb, sample_out, running, level);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (status() !== {8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1}) begin
      n_fail++; $display("FAIL reset_mid got %h exp %h", status(), {8'h00, 7'b0000001});
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

`ifdef FIR_FEEDER_LOOP_EN
  task automatic test_loop();
    logic [7:0] seq [3];
    seq = '{8'hA0, 8'hB0, 8'hC0};
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_data = seq[i]; tick();
    end
    wr_valid = 1'b0;
    loop = 1'b1; div = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      n_chk++;
      if ({sample_stb, sample_out, level, underflow, wr_ready} !==
          {1'b1, seq[i % 3], 4'd3, 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL loop t%0d got %b/%h/%0d/%b/%b exp 1/%h/3/0/0",
                           i, sample_stb, sample_out, level, underflow, wr_ready, seq[i % 3]);
      end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0; loop = 1'b0;
  endtask
`endif

  initial begin
    rst_n = 1'b0; ena = 1'b1; wr_data = '0; wr_valid = 1'b0;
    start = 1'b0; stop = 1'b0; div = '0;
`ifdef FIR_FEEDER_LOOP_EN
    loop = 1'b0;
`endif
    test_reset();
    test_fill();
    test_stream();
    test_stop_restart();
    test_underflow();
    test_ena();
    test_back_to_back();
    test_reset_mid();
`ifdef FIR_FEEDER_LOOP_EN
    test_loop();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_sample_feeder.md
Name: fir_sample_feeder

Overview:
Sample source for the tt_um_fir datapath. It drives the FIR's sample input, where the FIR consumes and this block produces. A host loads samples into a small FIFO over a byte valid/ready interface. The block then emits one sample per programmable sample period, as a held sample bus plus a one-cycle strobe. Buffer underflow is reported through a sticky flag.

Parameters:
DATA_W, 8, sample width in bits; matches the FIR input bus.
DEPTH, 8, FIFO depth in entries; must be a power of 2, minimum 2.
DIV_W, 8, width of the sample-period divider.

Ports:
clk  input  1  Single clock. All state updates on the rising edge.
rst_n  input  1  Reset: asynchronous, active-low. Clears all state.
ena  input  1  Block enable. When low, all state freezes.
wr_data  input  DATA_W  Sample to be written into the FIFO.
wr_valid  input  1  Host write request.
wr_ready  output  1  FIFO can accept a write.
start  input  1  Pulse. Begins streaming.
stop  input  1  Pulse. Halts streaming.
div  input  DIV_W  Sample period in clocks, minus 1.
sample_out  output  DATA_W  Current sample to the FIR. Registered and held between strobes.
sample_stb  output  1  One-cycle pulse when sample_out updates.
running  output  1  High in the RUN state.
underflow  output  1  Sticky flag. Set when a sample is due and the FIFO is empty.
level  output  $clog2(DEPTH)+1  Current FIFO occupancy.

Behaviour:
- Reset values: sample_out=0, sample_stb=0, running=0, underflow=0, level=0, wr_ready=1. State is IDLE, pointers and divider counter are 0.
- FIFO write:
  - A write is accepted on an edge where ena && wr_valid && wr_ready.
  - wr_ready = ena && (level < DEPTH). It is derived from registered occupancy.
  - When full, a write is rejected even if a pop happens in the same cycle.
  - Pointers wrap modulo DEPTH.
- State machine: two states, IDLE and RUN. running = (state==RUN).
- IDLE -> RUN:
  - Taken on an edge with ena && start && !stop.
  - At that edge: cnt <= div, underflow <= 0.
- RUN, each enabled edge:
  - If stop: go to IDLE. No pop, no strobe, FIFO contents kept. stop beats start and beats a due sample.
  - Else if cnt==0: sample is due. cnt <= div (div is sampled at reload only).
    - FIFO non-empty: sample_out <= head, pop, sample_stb <= 1.
    - FIFO empty: sample_out <= 0, sample_stb <= 1, underflow <= 1.
  - Else: cnt <= cnt-1, sample_stb <= 0.
- Timing: with start accepted at edge k, strobes occur at edges k+div+1, k+2(div+1), ... Period is exactly div+1 clocks; div=0 gives a strobe every clock.
- No fall-through: a write and a due pop in the same cycle on an empty FIFO counts as underflow. The written value is stored and popped later.
- Simultaneous push and pop on a non-empty, non-full FIFO leaves level unchanged.
- start while already in RUN is ignored. stop while in IDLE is ignored.
- ena low: no state changes, wr_ready=0, sample_stb <= 0. sample_out holds.
- Asynchronous reset mid-operation returns everything to the reset values immediately. FIFO contents are discarded.
- underflow clears only on reset or on an accepted start.

Optional Feature:
Macro FIR_FEEDER_LOOP_EN.
- Defined:
  - Adds input port loop (1 bit).
  - While in RUN with loop=1, each popped entry is rewritten at the tail in the same cycle. The buffer replays cyclically, level stays constant, and wr_ready is forced 0.
  - Underflow still applies when level=0.
- Undefined: no loop port. Behaviour is identical to loop=0.

Test Plan:
1. Assert rst_n=0, then release -> sample_out=0x00, sample_stb=0, running=0, underflow=0, level=0, wr_ready=1.
2. Write 0x01..0x08 back-to-back -> level=8 and wr_ready=0 after the 8th; a 9th write of 0xFF is not stored.
3. div=3, pulse start at edge k -> sample_stb at k+4, k+8, ..., sample_out 0x01, 0x02, ..., level decrements by 1 per strobe.
4. Continue past empty -> next strobe gives sample_out=0x00 and underflow=1, which stays set. A later start clears it.
5. Pulse stop with 3 entries left -> running=0, no strobes, level=3 holds. Restart -> next sample is 0x06.
   Second case: assert rst_n=0 mid-run -> all outputs 0 at once.
6. Loop build: load 0xA0, 0xB0, 0xC0; set loop=1, div=0, start -> outputs A0, B0, C0, A0, ... one per clock, level=3, underflow=0, wr_ready=0.
